// File: rtl/bridge_pulse_gen_if.sv
// Control and gate-drive signal bundle for the H-bridge pulse generator.
// The bench drives through master; the generator connects through slave.
interface bridge_pulse_gen_if #(
  parameter int HALF_W = 16,
  parameter int DEAD_W = 8,
  parameter int NCYC_W = 8
) ();
  logic              pluse_load;
  logic [HALF_W-1:0] qq_para;
  logic [DEAD_W-1:0] dead_para;
  logic [NCYC_W-1:0] bri_para;
  logic              phase;
  logic              state_start;
  logic              abort;
  logic              Q1Q8;
  logic              Q4Q5;
  logic              Q3Q6;
  logic              Q2Q7;
  logic              up;
  logic              down;
  logic              bri_cycle;
  logic              done;

  modport master (
    output pluse_load, qq_para, dead_para, bri_para, phase, state_start, abort,
    input  Q1Q8, Q4Q5, Q3Q6, Q2Q7, up, down, bri_cycle, done
  );

  modport slave (
    input  pluse_load, qq_para, dead_para, bri_para, phase, state_start, abort,
    output Q1Q8, Q4Q5, Q3Q6, Q2Q7, up, down, bri_cycle, done
  );
endinterface

// File: rtl/bridge_pulse_gen.sv
// H-bridge burst generator: alternating half-periods separated by dead time,
// shadow-loaded parameters, safe abort via a dead-time flush.
module bridge_pulse_gen #(
  parameter int HALF_W   = 16,
  parameter int DEAD_W   = 8,
  parameter int NCYC_W   = 8,
  parameter int MIN_DEAD = 2
) (
  input logic                clk_sys,
  input logic                rst,
  bridge_pulse_gen_if.slave  bus
);
  localparam int CNT_W = (HALF_W > DEAD_W) ? HALF_W : DEAD_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALF_A = 3'd1,
    DEAD_A = 3'd2,
    HALF_B = 3'd3,
    DEAD_B = 3'd4,
    FLUSH  = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic logic [HALF_W-1:0] eff_half(input logic [HALF_W-1:0] q);
    return (q == '0) ? HALF_W'(1) : q;
  endfunction

  function automatic logic [DEAD_W-1:0] eff_dead(input logic [DEAD_W-1:0] d);
    return (d < DEAD_W'(MIN_DEAD)) ? DEAD_W'(MIN_DEAD) : d;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [NCYC_W-1:0] cyc_r;
  logic [HALF_W-1:0] sh_half_r, wk_half_r, ld_half_s;
  logic [DEAD_W-1:0] sh_dead_r, wk_dead_r, ld_dead_s;
  logic [NCYC_W-1:0] sh_bri_r, wk_bri_r, ld_bri_s;
  logic              sh_phase_r, wk_phase_r, ld_phase_s;
  logic              half_last_s, dead_last_s, ph_s, pos_s, neg_s, run_s;
  logic              pos_r, neg_r, run_r, done_r;

  // Parameters a start in this cycle would use: same-cycle load wins over shadow.
  always_comb begin
    ld_half_s  = bus.pluse_load ? bus.qq_para   : sh_half_r;
    ld_dead_s  = bus.pluse_load ? bus.dead_para : sh_dead_r;
    ld_bri_s   = bus.pluse_load ? bus.bri_para  : sh_bri_r;
    ld_phase_s = bus.pluse_load ? bus.phase     : sh_phase_r;
  end

  // Next-state logic; abort outranks every other transition in active states.
  always_comb begin
    state_s     = state_r;
    half_last_s = (cnt_r == CNT_W'(wk_half_r - HALF_W'(1)));
    dead_last_s = (cnt_r == CNT_W'(wk_dead_r - DEAD_W'(1)));
    case (state_r)
      IDLE: begin
        if (bus.state_start && !bus.abort) begin
          state_s = (ld_bri_s == '0) ? DONE : HALF_A;
        end else begin
          state_s = IDLE;
        end
      end
      HALF_A: begin
        if (bus.abort)        state_s = FLUSH;
        else if (half_last_s) state_s = DEAD_A;
        else                  state_s = HALF_A;
      end
      DEAD_A: begin
        if (bus.abort)        state_s = FLUSH;
        else if (dead_last_s) state_s = HALF_B;
        else                  state_s = DEAD_A;
      end
      HALF_B: begin
        if (bus.abort)        state_s = FLUSH;
        else if (half_last_s) state_s = DEAD_B;
        else                  state_s = HALF_B;
      end
      DEAD_B: begin
        if (bus.abort) begin
          state_s = FLUSH;
        end else if (dead_last_s) begin
          state_s = (cyc_r == wk_bri_r - NCYC_W'(1)) ? DONE : HALF_A;
        end else begin
          state_s = DEAD_B;
        end
      end
      FLUSH: begin
        if (dead_last_s) state_s = IDLE;
        else             state_s = FLUSH;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered drives line up with it.
  always_comb begin
    ph_s  = (state_r == IDLE) ? ld_phase_s : wk_phase_r;
    pos_s = ((state_s == HALF_A) && !ph_s) || ((state_s == HALF_B) && ph_s);
    neg_s = ((state_s == HALF_A) && ph_s)  || ((state_s == HALF_B) && !ph_s);
    run_s = (state_s == HALF_A) || (state_s == DEAD_A) || (state_s == HALF_B) ||
            (state_s == DEAD_B) || (state_s == FLUSH);
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Length counter restarts on every state change; cycle counter advances at DEAD_B exit.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt_r <= '0;
      cyc_r <= '0;
    end else begin
      if ((state_s != state_r) || (state_r == IDLE) || (state_r == DONE)) cnt_r <= '0;
      else                                                                 cnt_r <= cnt_r + CNT_W'(1);
      if (state_r == IDLE)                                  cyc_r <= '0;
      else if ((state_r == DEAD_B) && (state_s == HALF_A)) cyc_r <= cyc_r + NCYC_W'(1);
      else                                                  cyc_r <= cyc_r;
    end
  end

  // Shadow registers follow every load strobe regardless of state.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sh_half_r  <= HALF_W'(1);
      sh_dead_r  <= DEAD_W'(MIN_DEAD);
      sh_bri_r   <= '0;
      sh_phase_r <= 1'b0;
    end else if (bus.pluse_load) begin
      sh_half_r  <= bus.qq_para;
      sh_dead_r  <= bus.dead_para;
      sh_bri_r   <= bus.bri_para;
      sh_phase_r <= bus.phase;
    end else begin
      sh_half_r  <= sh_half_r;
      sh_dead_r  <= sh_dead_r;
      sh_bri_r   <= sh_bri_r;
      sh_phase_r <= sh_phase_r;
    end
  end

  // Working copy is frozen at an accepted start and holds for the whole burst.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wk_half_r  <= HALF_W'(1);
      wk_dead_r  <= DEAD_W'(MIN_DEAD);
      wk_bri_r   <= '0;
      wk_phase_r <= 1'b0;
    end else if ((state_r == IDLE) && bus.state_start && !bus.abort) begin
      wk_half_r  <= eff_half(ld_half_s);
      wk_dead_r  <= eff_dead(ld_dead_s);
      wk_bri_r   <= ld_bri_s;
      wk_phase_r <= ld_phase_s;
    end else begin
      wk_half_r  <= wk_half_r;
      wk_dead_r  <= wk_dead_r;
      wk_bri_r   <= wk_bri_r;
      wk_phase_r <= wk_phase_r;
    end
  end

  // Registered gate drives and status.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pos_r  <= 1'b0;
      neg_r  <= 1'b0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      pos_r  <= pos_s;
      neg_r  <= neg_s;
      run_r  <= run_s;
      done_r <= (state_s == DONE);
    end
  end

  assign bus.Q1Q8      = pos_r;
  assign bus.Q4Q5      = pos_r;
  assign bus.up        = pos_r;
  assign bus.Q3Q6      = neg_r;
  assign bus.Q2Q7      = neg_r;
  assign bus.down      = neg_r;
  assign bus.bri_cycle = run_r;
  assign bus.done      = done_r;
endmodule

// File: doc/bridge_pulse_gen.md
BRIDGE_PULSE_GEN -- requirements
Module: bridge_pulse_gen

Interface
REQ-001 SHALL have parameter HALF_W, default 16: width of the half-period length field.
REQ-002 SHALL have parameter DEAD_W, default 8: width of the dead-time length field.
REQ-003 SHALL have parameter NCYC_W, default 8: width of the bridge cycle-count field.
REQ-004 SHALL have parameter MIN_DEAD, default 2: hardware floor on dead time, in clocks.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_sys, input, 1 bit: system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port pluse_load, input, 1 bit: 1-clock strobe that captures qq_para, dead_para, bri_para and phase into shadow registers.
REQ-009 SHALL have port qq_para, input, HALF_W bits: half-period length in clocks.
REQ-010 SHALL have port dead_para, input, DEAD_W bits: requested dead time in clocks.
REQ-011 SHALL have port bri_para, input, NCYC_W bits: number of full bridge cycles.
REQ-012 SHALL have port phase, input, 1 bit: start polarity (0 = positive first, 1 = negative first).
REQ-013 SHALL have port state_start, input, 1 bit: 1-clock start strobe.
REQ-014 SHALL have port abort, input, 1 bit: 1-clock safe-stop strobe.
REQ-015 SHALL have outputs Q1Q8, Q4Q5, Q3Q6 and Q2Q7, 1 bit each: bridge switch-pair gate drives.
REQ-016 SHALL have outputs up and down, 1 bit each: positive / negative half active.
REQ-017 SHALL have output bri_cycle, 1 bit: high while a burst or flush is in progress.
REQ-018 SHALL have output done, 1 bit: 1-clock pulse at normal burst completion.

Function
REQ-019 SHALL implement states IDLE, HALF_A, DEAD_A, HALF_B, DEAD_B, FLUSH, DONE.
REQ-020 SHALL, in the positive half, drive Q1Q8 = Q4Q5 = up = 1 and all other drives 0.
REQ-021 SHALL, in the negative half, drive Q3Q6 = Q2Q7 = down = 1 and all other drives 0.
REQ-022 SHALL, in the DEAD, FLUSH, IDLE and DONE states, drive all four gates, up and down to 0.
REQ-023 SHALL make HALF_A the positive half when the shadow phase = 0 and the negative half otherwise; HALF_B is the opposite half.
REQ-024 SHALL register all outputs; a positive and a negative pair are never high in the same cycle.
REQ-025 SHALL hold each half for max(qq_para, 1) clocks (qq_para = 0 treated as 1).
REQ-026 SHALL hold each DEAD state for eff_dead = max(dead_para, MIN_DEAD) clocks.
REQ-027 SHALL make one cycle HALF_A -> DEAD_A -> HALF_B -> DEAD_B; the cycle counter increments at the DEAD_B exit.
REQ-028 SHALL, at the DEAD_B exit, go to DONE when count = bri_para, else to HALF_A.
REQ-029 SHALL accept state_start only in IDLE; HALF_A outputs appear on the clock after the start edge (latency 1).
REQ-030 SHALL ignore state_start outside IDLE.
REQ-031 SHALL, on a start with bri_para = 0, go directly to DONE with no gate activity.
REQ-032 SHALL hold DONE for 1 clock with done = 1, then return to IDLE.
REQ-033 SHALL assert bri_cycle in HALF_A, DEAD_A, HALF_B, DEAD_B and FLUSH.
REQ-034 SHALL deassert bri_cycle in IDLE and DONE.
REQ-035 SHALL update shadow registers on pluse_load in any state; the running burst uses values latched at state_start (working copy) and is unaffected.
REQ-036 SHALL let pluse_load and state_start in the same IDLE cycle start with the newly loaded values.
REQ-037 SHALL, on abort in any HALF or DEAD state, drive all gates to 0 on the next clock and enter FLUSH.
REQ-038 SHALL hold FLUSH for eff_dead clocks, then go to IDLE without pulsing done.
REQ-039 SHALL give abort priority over state_start in the same cycle; abort in IDLE or DONE has no effect beyond this.
REQ-040 SHALL use HALF_W-bit length counters that never wrap: the maximum qq_para yields exactly 2^HALF_W - 1 clocks.

Reset
REQ-041 SHALL, with rst high, force state IDLE, all outputs 0, counters 0, and shadow registers to qq_para = 1, dead_para = MIN_DEAD, bri_para = 0, phase = 0.
REQ-042 SHALL, with rst asserted mid-burst, drive gates to 0 on the next clock; the next burst requires a new state_start.

Verification
REQ-043 SHALL cover: load qq=4, dead=3, bri=2, phase=0, then start -> Q1Q8/Q4Q5 high 4, all low 3, Q3Q6/Q2Q7 high 4, low 3, repeated; done pulses at clock 29 after start; bri_cycle high clocks 1-28.
REQ-044 SHALL cover: dead=0, MIN_DEAD=2, phase=1 -> negative half first; dead gaps are exactly 2 clocks.
REQ-045 SHALL cover: abort in the 2nd clock of HALF_B -> gates 0 next clock; bri_cycle stays high 3 clocks (FLUSH), then IDLE; done never pulses.
REQ-046 SHALL cover: bri=0 start -> done 1 clock after start, no gate activity; start again during a burst -> ignored, burst length unchanged.
REQ-047 SHALL cover: pluse_load qq=9 mid-burst -> current burst keeps qq=4; the next burst uses 9.
REQ-048 SHALL cover: rst pulsed mid-HALF_A -> all outputs 0 next clock; a checker asserts no simultaneous positive and negative pair over all tests.
